// File: rtl/ip1_wm_stream_ctrl_if.sv
// Load and weight valid/ready streams of the ip1 weight-SRAM controller.
// master is the controller side; slave is the producer/consumer side.
interface ip1_wm_stream_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ip1_wm_stream_ctrl.sv
// Loads weights into the ip1 SRAM from a stream, or streams them back out in address order.
// First read word is valid two cycles after rd_start; a 2-entry skid FIFO covers SRAM latency under m_ready stalls.
module ip1_wm_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  load_start,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    ip1_wm_stream_ctrl_if.master  strm,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ} state_t;

    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   ptr;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   len_m1;
    logic                  len_ok;
    logic                  is_last;
    logic                  done_nxt;
    logic                  cfg_err_nxt;
    logic                  start_op;
    logic                  ptr_inc;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occ_after_pop;
    logic                  inflight;
    logic                  inflight_last;
    logic [DATA_WIDTH-1:0] fifo_dat [2];
    logic                  fifo_lst [2];
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            fifo_cnt;

    assign len_ok        = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign len_m1        = len - PTR_ONE;
    assign is_last       = (ptr == len_m1);
    assign pop           = strm.m_valid && strm.m_ready;
    // Words already owed to the consumer once this cycle's pop retires.
    assign occ_after_pop = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

    assign busy         = (state != ST_IDLE);
    assign strm.s_ready = (state == ST_LOAD);
    assign strm.m_valid = (fifo_cnt != 2'd0);
    assign strm.m_data  = fifo_dat[rd_sel];
    assign strm.m_last  = fifo_lst[rd_sel] && strm.m_valid;
    assign sram_din0    = strm.s_data;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        cfg_err_nxt = 1'b0;
        start_op    = 1'b0;
        ptr_inc     = 1'b0;
        issue       = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_addr0  = ptr[ADDR_WIDTH-1:0];
        case (state)
            ST_IDLE: begin
                if (load_start || rd_start) begin
                    if (!len_ok) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        start_op  = 1'b1;
                        state_nxt = load_start ? ST_LOAD : ST_READ;
                    end
                end
            end
            ST_LOAD: begin
                sram_csb0 = !strm.s_valid;
                sram_web0 = 1'b0;
                if (strm.s_valid) begin
                    ptr_inc = 1'b1;
                    if (is_last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if ((ptr < len) && (occ_after_pop < 3'd2)) begin
                    issue     = 1'b1;
                    ptr_inc   = 1'b1;
                    sram_csb0 = 1'b0;
                end
                if (pop && strm.m_last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            ptr           <= '0;
            len           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (start_op) begin
                ptr <= '0;
                len <= cfg_len;
            end else if (ptr_inc) begin
                ptr <= ptr + PTR_ONE;
            end
            inflight      <= issue;
            inflight_last <= issue && is_last;
        end
    end

    // dout0 is only meaningful on the edge right after the issuing edge.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            fifo_dat[0] <= '0;
            fifo_dat[1] <= '0;
            fifo_lst[0] <= 1'b0;
            fifo_lst[1] <= 1'b0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_dat[wr_sel] <= sram_dout0;
                fifo_lst[wr_sel] <= inflight_last;
                wr_sel           <= !wr_sel;
            end
            if (pop) begin
                rd_sel <= !rd_sel;
            end
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= done_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    a_fifo_bound: assert property (@(posedge clk0) disable iff (!rst0_n)
        (3'(fifo_cnt) + 3'(inflight)) <= 3'd2);

endmodule

// File: tb/tb_ip1_wm_stream_ctrl.sv
// Self-checking bench for ip1_wm_stream_ctrl with a behavioural OpenRAM-style SRAM and a scoreboard.
module tb_ip1_wm_stream_ctrl;
    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        load_start;
    logic        rd_start;
    logic [8:0]  cfg_len;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        sram_csb0;
    logic        sram_web0;
    logic [7:0]  sram_addr0;
    logic [15:0] sram_din0;
    logic [15:0] sram_dout0;

    always #5 clk0 = ~clk0;

    ip1_wm_stream_ctrl_if #(.DATA_WIDTH(16)) strm();

    ip1_wm_stream_ctrl dut (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .load_start (load_start),
        .rd_start   (rd_start),
        .cfg_len    (cfg_len),
        .strm       (strm),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q [$];
    logic [15:0] model [256];
    logic [15:0] ram [256];
    int          beats = 0;
    int          done_cnt = 0;
    int          sram_acc = 0;
    int          outst = 0;
    int          max_outst = 0;
    bit          hold_v = 1'b0;
    logic [16:0] hold_d;
    logic [16:0] mon_got;
    logic [16:0] mon_exp;
    logic        ram_csb = 1'b1;
    logic        ram_web = 1'b1;
    logic [7:0]  ram_addr = '0;
    logic [15:0] ram_din = '0;

    // Inputs registered at posedge, write/read performed at negedge; dout is garbage otherwise.
    always @(posedge clk0 or negedge clk0) begin
        if (clk0) begin
            ram_csb    <= sram_csb0;
            ram_web    <= sram_web0;
            ram_addr   <= sram_addr0;
            ram_din    <= sram_din0;
            sram_dout0 <= 16'($urandom);
        end else if (!ram_csb) begin
            if (!ram_web) ram[ram_addr] <= ram_din;
            else          sram_dout0 <= ram[ram_addr];
        end
    end

    function automatic logic [15:0] pat_word(input int mode, input int i);
        case (mode)
            0:       return 16'(i) ^ 16'hA5A5;
            1:       return 16'h1234;
            default: return 16'hB000 | 16'(i);
        endcase
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk0);
            if (!rst0_n) begin
                hold_v = 1'b0;
                outst  = 0;
            end else begin
                mon_got = {strm.m_last, strm.m_data};
                if (hold_v) begin
                    checks++;
                    if (!strm.m_valid || mon_got !== hold_d) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", strm.m_valid, mon_got, hold_d);
                    end
                end
                hold_v = strm.m_valid && !strm.m_ready;
                hold_d = mon_got;
                if (strm.m_valid && strm.m_ready) begin
                    beats++;
                    outst--;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got beat %h, required none", mon_got);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL sb_data: got {last,data}=%h, required %h", mon_got, mon_exp);
                        end
                    end
                end
                if (!sram_csb0) sram_acc++;
                if (!sram_csb0 && sram_web0) outst++;
                if (outst > max_outst) max_outst = outst;
                if (done) done_cnt++;
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_load(input int len, input int mode, input bit inject);
        int          i;
        int          cyc;
        int          d0;
        bit          v;
        bit          injected;
        logic [15:0] dat;
        d0 = done_cnt;
        cfg_len = 9'(len);
        load_start = 1'b1;
        rd_start = inject;
        @(posedge clk0); #1;
        load_start = 1'b0;
        rd_start = 1'b0;
        checks++;
        if ({busy, strm.s_ready} !== 2'b11) begin
            errors++;
            $display("FAIL load_enter: got busy,s_ready=%b, required 11", {busy, strm.s_ready});
        end
        i = 0;
        cyc = 0;
        while (i < len && cyc < 2000) begin
            v = ($urandom_range(0, 3) != 0);
            dat = pat_word(mode, i);
            strm.s_valid = v;
            strm.s_data = dat;
            injected = inject && (i == 1);
            load_start = injected;
            rd_start = injected;
            cfg_len = injected ? 9'd0 : 9'(len);
            #1;
            checks++;
            if (v) begin
                if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {2'b00, 8'(i), dat}) begin
                    errors++;
                    $display("FAIL load_write: got csb=%b web=%b addr=%h din=%h, required 0 0 %h %h",
                             sram_csb0, sram_web0, sram_addr0, sram_din0, 8'(i), dat);
                end
            end else if (sram_csb0 !== 1'b1) begin
                errors++;
                $display("FAIL load_idle_cs: got csb=%b, required 1", sram_csb0);
            end
            @(posedge clk0); #1;
            if (v) begin
                model[i] = dat;
                i++;
            end
            cyc++;
            load_start = 1'b0;
            rd_start = 1'b0;
            if (injected && i < len) begin
                checks++;
                if ({cfg_err, busy, strm.s_ready} !== 3'b011) begin
                    errors++;
                    $display("FAIL start_in_load: got cfg_err,busy,s_ready=%b, required 011", {cfg_err, busy, strm.s_ready});
                end
            end
        end
        strm.s_valid = 1'b0;
        checks++;
        if (i != len) begin
            errors++;
            $display("FAIL load_timeout: got %0d beats, required %0d", i, len);
        end
        checks++;
        if ({done, busy, strm.s_ready} !== 3'b100) begin
            errors++;
            $display("FAIL load_done: got done,busy,s_ready=%b, required 100", {done, busy, strm.s_ready});
        end
        @(posedge clk0); #1;
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL load_done_once: got done=%b count=%0d, required 0 and 1", done, done_cnt - d0);
        end
    endtask

    task automatic do_read(input int len, input bit rnd, input bit timing);
        int cyc;
        int d0;
        int b0;
        int first;
        int gaps;
        bit seen;
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), model[i]});
        d0 = done_cnt;
        b0 = beats;
        first = -1;
        gaps = 0;
        seen = 1'b0;
        cfg_len = 9'(len);
        rd_start = 1'b1;
        strm.m_ready = 1'b1;
        @(posedge clk0); #1;
        rd_start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (strm.m_valid && !seen) begin
                seen = 1'b1;
                first = cyc;
            end else if (seen && !strm.m_valid) begin
                gaps++;
            end
            strm.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk0); #1;
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout: got no done after %0d cycles, required done", cyc);
        end
        checks++;
        if (beats - b0 != len || exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_count: got %0d beats (%0d left), required %0d (0 left)", beats - b0, exp_q.size(), len);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got busy=%b, required 0", busy);
        end
        if (timing) begin
            checks++;
            if (first != 2 || gaps != 0) begin
                errors++;
                $display("FAIL read_timing: got first_valid=%0d gaps=%0d, required 2 and 0", first, gaps);
            end
        end
        strm.m_ready = 1'b0;
        @(posedge clk0); #1;
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL read_done_once: got done=%b count=%0d, required 0 and 1", done, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk0);
        #1;
        checks++;
        if ({strm.s_ready, strm.m_valid, strm.m_last, busy, done, cfg_err, sram_csb0, sram_web0} !== 8'b00000011) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000011",
                     {strm.s_ready, strm.m_valid, strm.m_last, busy, done, cfg_err, sram_csb0, sram_web0});
        end
        rst0_n = 1'b1;
        @(posedge clk0); #1;
        checks++;
        if ({busy, sram_csb0, strm.m_valid} !== 3'b010) begin
            errors++;
            $display("FAIL reset_release: got busy,csb,m_valid=%b, required 010", {busy, sram_csb0, strm.m_valid});
        end
    endtask

    task automatic test_full_load_read();
        do_load(256, 0, 1'b0);
        do_read(256, 1'b0, 1'b1);
    endtask

    task automatic test_random_ready();
        max_outst = 0;
        do_read(256, 1'b1, 1'b0);
        checks++;
        if (max_outst > 2 || max_outst < 1) begin
            errors++;
            $display("FAIL outstanding: got max %0d, required 1..2", max_outst);
        end
    endtask

    task automatic test_len1();
        do_load(1, 1, 1'b0);
        do_read(1, 1'b0, 1'b1);
    endtask

    task automatic test_cfg_err();
        int lens [2];
        int a0;
        lens[0] = 0;
        lens[1] = 257;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 2; k++) begin
                a0 = sram_acc;
                cfg_len = 9'(lens[l]);
                load_start = (k == 0);
                rd_start = (k == 1);
                @(posedge clk0); #1;
                load_start = 1'b0;
                rd_start = 1'b0;
                checks++;
                if ({cfg_err, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL cfg_err_pulse: len=%0d kind=%0d got cfg_err,busy=%b, required 10", lens[l], k, {cfg_err, busy});
                end
                @(posedge clk0); #1;
                checks++;
                if ({cfg_err, busy, sram_csb0} !== 3'b001 || sram_acc != a0) begin
                    errors++;
                    $display("FAIL cfg_err_quiet: len=%0d got cfg_err,busy,csb=%b accesses=%0d, required 001 and 0",
                             lens[l], {cfg_err, busy, sram_csb0}, sram_acc - a0);
                end
            end
        end
    endtask

    task automatic test_both_starts();
        do_load(4, 2, 1'b1);
        do_read(4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        int b0;
        int d0;
        int cyc;
        int late_done;
        for (int i = 0; i < 256; i++) exp_q.push_back({(i == 255), model[i]});
        b0 = beats;
        d0 = done_cnt;
        cfg_len = 9'd256;
        rd_start = 1'b1;
        strm.m_ready = 1'b1;
        @(posedge clk0); #1;
        rd_start = 1'b0;
        cyc = 0;
        while (beats - b0 < 10 && cyc < 100) begin
            @(posedge clk0); #1;
            cyc++;
        end
        checks++;
        if (beats - b0 != 10) begin
            errors++;
            $display("FAIL midrd_beats: got %0d beats, required 10", beats - b0);
        end
        #2;
        rst0_n = 1'b0;
        #1;
        checks++;
        if ({sram_csb0, strm.m_valid, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL midrd_reset: got csb,m_valid,busy,done=%b, required 1000", {sram_csb0, strm.m_valid, busy, done});
        end
        exp_q.delete();
        repeat (2) @(posedge clk0);
        #1;
        rst0_n = 1'b1;
        late_done = 0;
        repeat (3) begin
            @(posedge clk0); #1;
            if (done) late_done++;
        end
        checks++;
        if (late_done != 0 || done_cnt != d0) begin
            errors++;
            $display("FAIL midrd_no_done: got %0d done pulses, required 0", late_done + done_cnt - d0);
        end
        do_read(4, 1'b0, 1'b1);
    endtask

    initial begin
        rst0_n = 1'b0;
        load_start = 1'b0;
        rd_start = 1'b0;
        cfg_len = '0;
        strm.s_valid = 1'b0;
        strm.s_data = '0;
        strm.m_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_full_load_read();
        test_random_ready();
        test_len1();
        test_cfg_err();
        test_both_starts();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
